stream_downsize: RTL
====================

Name: stream_downsize

Overview:
- Wide-to-narrow stream converter; inverse of stream_upsize.
- Accepts one wide beat of T_DATA_RATIO lanes with a per-lane keep mask and a packet-last flag.
- Serialises the kept lanes, lowest index first, onto a narrow valid/ready stream, preserving packet boundaries.
- Sits at the output of wide datapaths that feed narrow consumers.

Parameters:
- T_DATA_WIDTH, 4, width of one lane and of the narrow output word.
- T_DATA_RATIO, 2, number of lanes per wide input beat; must be >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_data_i  input  [T_DATA_WIDTH-1:0] x [T_DATA_RATIO-1:0]  wide beat; lane 0 is first in stream order.
- s_keep_i  input  T_DATA_RATIO  per-lane valid mask.
- s_last_i  input  1  beat ends a packet.
- s_valid_i  input  1  wide beat valid.
- s_ready_o  output  1  block can accept a wide beat.
- m_data_o  output  T_DATA_WIDTH  narrow word.
- m_last_o  output  1  final word of packet.
- m_valid_o  output  1  narrow word valid.
- m_ready_i  input  1  downstream accepts word.

Behaviour:
- Handshakes:
  - Input transfer when s_valid_i && s_ready_o at a rising edge.
  - Output transfer when m_valid_o && m_ready_i at a rising edge.
- Storage: one wide beat buffer holding data, a remaining-keep mask rem and a last flag.
- States:
  - IDLE: rem == 0.
  - SEND: rem != 0.
- s_ready_o = !rst && (IDLE || (m_ready_i && rem has exactly one bit set)).
  - Combinational path from m_ready_i to s_ready_o is intended; it gives zero-bubble back-to-back beats.
- On input transfer:
  - Buffer loads s_data_i.
  - rem <= s_keep_i.
  - Last flag <= s_last_i.
- Outputs:
  - m_valid_o = (rem != 0), registered state.
  - m_data_o = buffer lane at the lowest set bit of rem.
  - m_last_o = last flag && rem has exactly one bit set.
- On output transfer without a simultaneous input transfer: clear the lowest set bit of rem. Reaching 0 returns to IDLE.
- Simultaneous output transfer of the final word and input transfer: the new beat loads and the block stays in SEND with no idle cycle.
- Latency:
  - A beat accepted at edge N shows its first word from cycle N+1.
  - The beat occupies popcount(s_keep_i) output transfers.
- Sparse keep (e.g. 4'b1010) is legal; lanes with keep 0 are skipped, never emitted.
- Keep == 0 beat: accepted in one cycle and discarded; no output, and s_last_i on it is dropped. Upstream must not send last on an empty beat.
- Backpressure: while m_valid_o && !m_ready_i, m_data_o, m_last_o and m_valid_o hold stable and s_ready_o = 0.
- Reset values:
  - m_valid_o = 0, m_last_o = 0, m_data_o = 0, s_ready_o = 0 while rst is high.
  - Buffer data cleared to 0, rem = 0, last flag = 0.
- Reset mid-packet: all buffered words are discarded and no m_last_o is generated. The first cycle after rst deasserts is IDLE with s_ready_o = 1.
- s_* inputs are ignored while rst is high.

Test Plan (W=4, R=2 unless stated; m_ready_i=1 unless stated):
- Two beats back-to-back: lanes {0:1,1:2} keep 11 last 0, then {0:A,1:B} keep 11 last 1.
  - Required: m_data_o 1,2,A,B on 4 consecutive cycles.
  - m_last_o only with B.
  - s_ready_o high in the cycle word 2 is presented, so no bubble between 2 and A.
- Partial beat: lane0=C keep 01 last 1.
  - Required: single word C with m_last_o=1.
  - s_ready_o=1 in the same cycle (single remaining bit); next cycle IDLE if no new beat.
- Sparse beat: R=4, lanes {0:1,1:2,2:3,3:4} keep 1010 last 1.
  - Required: words 2 then 4; m_last_o only on 4.
- Backpressure: during a full beat {1,2}, hold m_ready_i=0 for 3 cycles while word 1 is shown.
  - Required: m_data_o=1 and m_valid_o=1 stable, s_ready_o=0.
  - Release gives 1 then 2.
- Empty beat: keep 00 last 0, followed by {5,6} keep 11 last 1.
  - Required: empty beat accepted in 1 cycle with m_valid_o=0; then 5, 6 with last on 6.
- Reset mid-packet: assert rst for 1 cycle after word 1 of {1,2} is transferred.
  - Required: m_valid_o=0 the cycle after reset; word 2 is never emitted.
  - The next beat {7,8} last 1 yields 7, 8 with last on 8.

Source files
------------

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: one wide beat of lanes with a keep mask is
// serialised, lowest kept lane first, onto a narrow valid/ready stream.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]                  s_keep_i,
    input  logic                                     s_last_i,
    input  logic                                     s_valid_i,
    output logic                                     s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                  m_data_o,
    output logic                                     m_last_o,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i
);

    localparam int IDX_W = $clog2(T_DATA_RATIO);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                                   state_q, state_d;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data_q, data_d;
    logic [T_DATA_RATIO-1:0]                  rem_q, rem_d;
    logic                                     last_q, last_d;

    logic [T_DATA_RATIO-1:0] lowBit;
    logic                    oneLeft;
    logic [IDX_W-1:0]        lowIdx;
    logic                    inFire;
    logic                    outFire;

    // Lowest pending lane, and whether it is the final one of the beat.
    always_comb begin
        lowBit  = rem_q & (~rem_q + T_DATA_RATIO'(1));
        oneLeft = (rem_q != '0) && ((rem_q & (rem_q - T_DATA_RATIO'(1))) == '0);
        lowIdx  = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                lowIdx = IDX_W'(i);
            end
        end
    end

    // Accepting while the last word leaves keeps back-to-back beats bubble-free.
    assign s_ready_o = !rst && ((state_q == IDLE) || (m_ready_i && oneLeft));
    assign m_valid_o = !rst && (state_q == SEND);
    assign m_data_o  = rst ? '0 : data_q[lowIdx];
    assign m_last_o  = !rst && last_q && oneLeft;

    assign inFire  = s_valid_i && s_ready_o;
    assign outFire = m_valid_o && m_ready_i;

    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        last_d = last_q;
        if (inFire) begin
            data_d = s_data_i;
            rem_d  = s_keep_i;
            last_d = s_last_i;
        end else if (outFire) begin
            rem_d = rem_q & ~lowBit;
        end
        state_d = (rem_d != '0) ? SEND : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
        end
    end

endmodule
